// File: rtl/router_pkg.sv
// Shared types and default widths for the tile read scheduler.
//
// Contents:
//   DEF_ADDR_WIDTH      default SPAD address width
//   DEF_TILE_CNT_WIDTH  default tile count / tile index width
//   tile_sched_state_e  scheduler FSM state encoding
package router_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 8;
    localparam int unsigned DEF_TILE_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WAIT_RDY = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } tile_sched_state_e;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile address / index generator for the tile read scheduler.
//
// Holds the start address and index of the tile in flight. load_i
// restarts the sequence at base_i with index 0; step_i moves to the next
// tile (address += stride_i, index += 1). Address arithmetic wraps modulo
// 2^ADDR_WIDTH with no overflow indication.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         restart at base_i, index 0 (wins over step_i)
//   base_i         start address of tile 0
//   step_i         advance to the next tile
//   stride_i       address increment between tiles
//   num_i          number of tiles in the job
//   cur_addr_o     start address of the current tile
//   tile_idx_o     index of the current tile
//   last_o         current tile is the final one (idx == num-1)
module tile_addr_gen
    import router_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TILE_CNT_WIDTH = DEF_TILE_CNT_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [ADDR_WIDTH-1:0]     base_i,
    input  logic                      step_i,
    input  logic [ADDR_WIDTH-1:0]     stride_i,
    input  logic [TILE_CNT_WIDTH-1:0] num_i,
    output logic [ADDR_WIDTH-1:0]     cur_addr_o,
    output logic [TILE_CNT_WIDTH-1:0] tile_idx_o,
    output logic                      last_o
);

    logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
    logic [TILE_CNT_WIDTH-1:0] tile_idx_q, tile_idx_d;

    always_comb begin
        cur_addr_d = cur_addr_q;
        tile_idx_d = tile_idx_q;
        if (load_i) begin
            cur_addr_d = base_i;
            tile_idx_d = '0;
        end else if (step_i) begin
            cur_addr_d = cur_addr_q + stride_i;
            tile_idx_d = tile_idx_q + TILE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_addr_q <= '0;
            tile_idx_q <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            tile_idx_q <= tile_idx_d;
        end
    end

    assign cur_addr_o = cur_addr_q;
    assign tile_idx_o = tile_idx_q;
    // num_i is never 0 while a job is active, so num_i-1 cannot underflow
    // at the point this is consumed.
    assign last_o     = (tile_idx_q == (num_i - TILE_CNT_WIDTH'(1)));

endmodule

// File: rtl/tile_read_scheduler.sv
// Tile read scheduler: walks one tile_reader through a programmed list of
// equally sized, equally strided tiles in a scratchpad.
//
// Per tile: clear the reader (CLEAR), wait for the router (WAIT_RDY),
// enable the reader with stable start/end addresses until it reports done
// (RUN), then move to the next tile or finish (DONE).
//
// Handshakes: i_start is a one-cycle request honoured only in IDLE and
// answered by exactly one of o_done, o_cfg_err or o_aborted (one-cycle
// pulses). i_router_ready is a level; a tile is launched on the cycle after
// it is seen high in WAIT_RDY. i_tr_done is a level sampled only in RUN.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_abort    job start pulse, job abort
//   i_base_addr, i_tile_stride, i_tile_len, i_num_tiles   job configuration
//   i_router_ready      router can take a new tile
//   i_tr_done           tile_reader read-done
//   o_tr_en, o_tr_reg_clear, o_tr_start_addr, o_tr_addr_end  tile_reader controls
//   o_tile_idx          index of the tile in flight
//   o_tile_start        pulse in the first RUN cycle of each tile
//   o_busy              high outside IDLE
//   o_done, o_aborted, o_cfg_err   job completion pulses
//   o_dbg_state         current FSM state
module tile_read_scheduler
    import router_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TILE_CNT_WIDTH = DEF_TILE_CNT_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [ADDR_WIDTH-1:0]     i_tile_stride,
    input  logic [ADDR_WIDTH-1:0]     i_tile_len,
    input  logic [TILE_CNT_WIDTH-1:0] i_num_tiles,
    input  logic                      i_router_ready,
    input  logic                      i_tr_done,
    output logic                      o_tr_en,
    output logic                      o_tr_reg_clear,
    output logic [ADDR_WIDTH-1:0]     o_tr_start_addr,
    output logic [ADDR_WIDTH-1:0]     o_tr_addr_end,
    output logic [TILE_CNT_WIDTH-1:0] o_tile_idx,
    output logic                      o_tile_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_aborted,
    output logic                      o_cfg_err,
    output tile_sched_state_e         o_dbg_state
);

    tile_sched_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]     stride_q, stride_d;
    logic [TILE_CNT_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0]     addr_end_q, addr_end_d;

    // One-cycle pulse flags raised by a transition and shown the cycle after.
    logic first_run_q, first_run_d;
    logic zero_done_q, zero_done_d;
    logic abort_q, abort_d;
    logic cfg_err_q, cfg_err_d;

    logic                      addr_load;
    logic                      addr_step;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [TILE_CNT_WIDTH-1:0] tile_idx;
    logic                      tile_last;

    tile_addr_gen #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TILE_CNT_WIDTH (TILE_CNT_WIDTH)
    ) u_addr_gen (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (addr_load),
        .base_i     (i_base_addr),
        .step_i     (addr_step),
        .stride_i   (stride_q),
        .num_i      (num_q),
        .cur_addr_o (cur_addr),
        .tile_idx_o (tile_idx),
        .last_o     (tile_last)
    );

    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        num_d       = num_q;
        addr_end_d  = addr_end_q;
        first_run_d = 1'b0;
        zero_done_d = 1'b0;
        abort_d     = 1'b0;
        cfg_err_d   = 1'b0;
        addr_load   = 1'b0;
        addr_step   = 1'b0;

        // Abort beats everything outside IDLE, including a same-cycle done.
        if ((state_q != IDLE) && i_abort) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_tile_len == '0) begin
                            cfg_err_d = 1'b1;
                        end else if (i_num_tiles == '0) begin
                            zero_done_d = 1'b1;
                        end else begin
                            stride_d   = i_tile_stride;
                            num_d      = i_num_tiles;
                            addr_end_d = i_tile_len - ADDR_WIDTH'(1);
                            addr_load  = 1'b1;
                            state_d    = CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    state_d = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (i_router_ready) begin
                        state_d     = RUN;
                        first_run_d = 1'b1;
                    end
                end
                RUN: begin
                    if (i_tr_done) begin
                        if (tile_last) begin
                            state_d = DONE;
                        end else begin
                            addr_step = 1'b1;
                            state_d   = CLEAR;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            num_q       <= '0;
            addr_end_q  <= '0;
            first_run_q <= 1'b0;
            zero_done_q <= 1'b0;
            abort_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            num_q       <= num_d;
            addr_end_q  <= addr_end_d;
            first_run_q <= first_run_d;
            zero_done_q <= zero_done_d;
            abort_q     <= abort_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign o_tr_en         = (state_q == RUN);
    // The reader is also cleared on the cycle after an abort so it does not
    // keep a half-finished tile.
    assign o_tr_reg_clear  = (state_q == CLEAR) | abort_q;
    assign o_tr_start_addr = cur_addr;
    assign o_tr_addr_end   = addr_end_q;
    assign o_tile_idx      = tile_idx;
    assign o_tile_start    = (state_q == RUN) & first_run_q;
    assign o_busy          = (state_q != IDLE);
    assign o_done          = (state_q == DONE) | zero_done_q;
    assign o_aborted       = abort_q;
    assign o_cfg_err       = cfg_err_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_tile_read_scheduler.sv
module tb_tile_read_scheduler;
    import router_pkg::*;

    localparam int AW = 8;
    localparam int TW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic [AW-1:0] i_base_addr;
    logic [AW-1:0] i_tile_stride;
    logic [AW-1:0] i_tile_len;
    logic [TW-1:0] i_num_tiles;
    logic          i_router_ready;
    logic          i_tr_done;
    logic          o_tr_en;
    logic          o_tr_reg_clear;
    logic [AW-1:0] o_tr_start_addr;
    logic [AW-1:0] o_tr_addr_end;
    logic [TW-1:0] o_tile_idx;
    logic          o_tile_start;
    logic          o_busy;
    logic          o_done;
    logic          o_aborted;
    logic          o_cfg_err;
    tile_sched_state_e dbg_state;

    tile_read_scheduler #(.ADDR_WIDTH(AW), .TILE_CNT_WIDTH(TW)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_base_addr     (i_base_addr),
        .i_tile_stride   (i_tile_stride),
        .i_tile_len      (i_tile_len),
        .i_num_tiles     (i_num_tiles),
        .i_router_ready  (i_router_ready),
        .i_tr_done       (i_tr_done),
        .o_tr_en         (o_tr_en),
        .o_tr_reg_clear  (o_tr_reg_clear),
        .o_tr_start_addr (o_tr_start_addr),
        .o_tr_addr_end   (o_tr_addr_end),
        .o_tile_idx      (o_tile_idx),
        .o_tile_start    (o_tile_start),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_aborted       (o_aborted),
        .o_cfg_err       (o_cfg_err),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [AW-1:0] exp_q[$];      // expected tile start addresses, in order
    logic [AW-1:0] exp_end;       // expected addr_end for every tile
    logic [AW-1:0] run_addr;      // expected address of the tile in RUN

    int n_start, n_done, n_clear, n_tile_clear, n_en, n_abort, n_cfg_err, n_given;
    bit busy_seen, done_prev, tr_done_prev, abort_prev;
    int rd_lat, en_cnt, abort_at, bp_cnt, bp_rise;
    bit bp_armed, stale_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe DUT at the falling edge, then drive the reader model,
    // router backpressure and abort for the next rising edge.
    task automatic tick();
        logic [AW-1:0] a;
        @(negedge clk);
        cyc++;
        if (done_prev)    check_eq("busy_after_done", 32'(o_busy), 0);
        if (tr_done_prev) check_eq("en_drop_after_done", 32'(o_tr_en), 0);
        if (abort_prev) begin
            check_eq("abort_pulse", 32'(o_aborted), 1);
            check_eq("abort_clear", 32'(o_tr_reg_clear), 1);
            check_eq("abort_en", 32'(o_tr_en), 0);
            check_eq("abort_idle", 32'(o_busy), 0);
        end
        if (o_busy)      busy_seen = 1'b1;
        if (o_done)      n_done++;
        if (o_tr_en)     n_en++;
        if (o_aborted)   n_abort++;
        if (o_cfg_err)   n_cfg_err++;
        if (o_tr_reg_clear) n_clear++;
        if (o_done && n_tile_clear > 0) check_eq("done_busy", 32'(o_busy), 1);
        if (o_tr_reg_clear && o_busy) begin
            n_tile_clear++;
            check_eq("clear_en", 32'(o_tr_en), 0);
            check_eq("clear_idx", 32'(o_tile_idx), n_start);
            if (exp_q.size() > 0) check_eq("clear_addr", 32'(o_tr_start_addr), 32'(exp_q[0]));
            check_eq("clear_end", 32'(o_tr_addr_end), 32'(exp_end));
        end
        if (o_tile_start) begin
            check_eq("start_en", 32'(o_tr_en), 1);
            check_eq("start_idx", 32'(o_tile_idx), n_start);
            check_eq("start_end", 32'(o_tr_addr_end), 32'(exp_end));
            if (exp_q.size() > 0) begin
                a = exp_q.pop_front();
                run_addr = a;
                check_eq("start_addr", 32'(o_tr_start_addr), 32'(a));
            end
            if (bp_rise >= 0) begin
                check_eq("bp_latency", cyc, bp_rise + 1);
                bp_rise = -1;
            end
            n_start++;
        end else if (o_tr_en) begin
            check_eq("run_addr_stable", 32'(o_tr_start_addr), 32'(run_addr));
            check_eq("run_end_stable", 32'(o_tr_addr_end), 32'(exp_end));
        end

        // router backpressure: hold ready low for 10 cycles after tile-1 clear
        if (bp_cnt > 0) begin
            check_eq("bp_en_low", 32'(o_tr_en), 0);
            bp_cnt--;
            if (bp_cnt == 0) begin
                i_router_ready = 1'b1;
                bp_rise = cyc;
            end
        end else if (bp_armed && o_tr_reg_clear && o_busy && o_tile_idx == TW'(1)) begin
            bp_armed = 1'b0;
            i_router_ready = 1'b0;
            bp_cnt = 10;
        end

        // tile_reader model: done after rd_lat enabled cycles
        i_abort = 1'b0;
        if (o_tr_en) en_cnt++;
        else         en_cnt = 0;
        if (o_tr_en && en_cnt == rd_lat) begin
            i_tr_done = 1'b1;
            if (abort_at == n_given) i_abort = 1'b1;
            n_given++;
        end else if (stale_en && o_busy && !o_tr_en && $urandom_range(0, 3) == 0) begin
            i_tr_done = 1'b1;   // stale done outside RUN must be ignored
        end else begin
            i_tr_done = 1'b0;
        end
        tr_done_prev = i_tr_done && o_tr_en;
        abort_prev   = i_abort;
        done_prev    = o_done;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_addrs"}, 32'({o_tr_start_addr, o_tr_addr_end, o_tile_idx}), 0);
        check_eq({tag, "_flags"}, 32'({o_tr_en, o_tr_reg_clear, o_tile_start, o_busy,
                                       o_done, o_aborted, o_cfg_err}), 0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // Build the reference for one job and issue the start pulse.
    task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [AW-1:0] len, input logic [TW-1:0] num,
                             input int lat, input bit bp, input int abort_tile, input bit noise);
        int v;
        exp_q.delete();
        exp_end = len - 8'd1;
        if (len != 0) begin
            for (int k = 0; k < int'(num); k++) begin
                v = (int'(base) + k * int'(stride)) % (1 << AW);
                exp_q.push_back(v[AW-1:0]);
            end
        end
        run_addr = base;
        n_start = 0; n_done = 0; n_clear = 0; n_tile_clear = 0; n_en = 0;
        n_abort = 0; n_cfg_err = 0; n_given = 0; busy_seen = 1'b0;
        rd_lat = lat; en_cnt = 0; abort_at = abort_tile; stale_en = noise;
        bp_armed = bp; bp_cnt = 0; bp_rise = -1;
        i_router_ready = 1'b1;
        i_tr_done = 1'b0;
        i_base_addr = base; i_tile_stride = stride; i_tile_len = len; i_num_tiles = num;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [AW-1:0] len, input logic [TW-1:0] num,
                           input int lat, input bit bp, input int abort_tile, input bit noise);
        bit timeout;
        start_job(base, stride, len, num, lat, bp, abort_tile, noise);
        if (len == 0) begin
            check_eq("cfg_err_pulse", 32'(o_cfg_err), 1);
        end else if (num == 0) begin
            check_eq("zero_done_pulse", 32'(o_done), 1);
            check_eq("zero_not_busy", 32'(o_busy), 0);
        end else begin
            check_eq("first_busy", 32'(o_busy), 1);
            check_eq("first_clear", 32'(o_tr_reg_clear), 1);
        end
        timeout = 1'b1;
        if (o_busy) begin
            for (int i = 0; i < 3000; i++) begin
                if (noise) begin
                    // start and config changes while busy must be ignored
                    i_start       = ($urandom_range(0, 5) == 0);
                    i_base_addr   = AW'($urandom_range(0, 255));
                    i_tile_stride = AW'($urandom_range(0, 255));
                    i_tile_len    = AW'($urandom_range(0, 255));
                    i_num_tiles   = TW'($urandom_range(0, 255));
                end
                tick();
                if (!o_busy) begin
                    timeout = 1'b0;
                    break;
                end
            end
        end else begin
            timeout = 1'b0;
        end
        i_start = 1'b0;
        check_eq("job_timeout", 32'(timeout), 0);
        tick();
        tick();

        if (len == 0) begin
            check_eq("cfg_err_cnt", n_cfg_err, 1);
            check_eq("cfg_no_busy", 32'(busy_seen), 0);
            check_eq("cfg_no_done", n_done, 0);
        end else if (num == 0) begin
            check_eq("zero_done_cnt", n_done, 1);
            check_eq("zero_no_clear", n_clear, 0);
            check_eq("zero_no_en", n_en, 0);
            check_eq("zero_no_busy", 32'(busy_seen), 0);
        end else if (abort_tile >= 0 && abort_tile < int'(num)) begin
            check_eq("abort_tiles", n_start, abort_tile + 1);
            check_eq("abort_no_done", n_done, 0);
            check_eq("abort_cnt", n_abort, 1);
            check_eq("abort_tile_clears", n_tile_clear, abort_tile + 1);
            check_eq("abort_en_cycles", n_en, (abort_tile + 1) * lat);
        end else begin
            check_eq("job_tiles", n_start, int'(num));
            check_eq("job_clears", n_tile_clear, int'(num));
            check_eq("job_done_cnt", n_done, 1);
            check_eq("job_no_abort", n_abort, 0);
            check_eq("job_en_cycles", n_en, int'(num) * lat);
            check_eq("job_all_tiles", exp_q.size(), 0);
        end
        check_eq("end_idle", 32'(o_busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int num;
        int ab;
        bit ok;
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_base_addr = '0; i_tile_stride = '0; i_tile_len = '0; i_num_tiles = '0;
        i_router_ready = 1'b1; i_tr_done = 1'b0;
        rd_lat = 1; en_cnt = 0; abort_at = -1; bp_cnt = 0; bp_rise = -1;
        bp_armed = 1'b0; stale_en = 1'b0; n_given = 0;
        done_prev = 1'b0; tr_done_prev = 1'b0; abort_prev = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        i_rst = 1'b0;
        tick();
        check_outputs_zero("idle_after_reset");

        // basic job
        run_job(8'h10, 8'h08, 8'd4, 8'd3, 5, 1'b0, -1, 1'b0);
        // router backpressure on tile 1
        run_job(8'h40, 8'h20, 8'd16, 8'd3, 3, 1'b1, -1, 1'b0);
        // address wrap
        run_job(8'hF8, 8'h10, 8'd8, 8'd2, 2, 1'b0, -1, 1'b0);
        // zero tiles
        run_job(8'h33, 8'h01, 8'd5, 8'd0, 2, 1'b0, -1, 1'b0);
        // config error
        run_job(8'h10, 8'h08, 8'd0, 8'd3, 2, 1'b0, -1, 1'b0);
        // abort together with done on tile 0 of 4
        run_job(8'h00, 8'h04, 8'd4, 8'd4, 3, 1'b0, 0, 1'b0);
        // extreme lengths
        run_job(8'h01, 8'h01, 8'd1, 8'd2, 1, 1'b0, -1, 1'b0);
        run_job(8'h00, 8'hFF, 8'd255, 8'd3, 2, 1'b0, -1, 1'b0);

        // reset while a tile is running, then a fresh job from tile 0
        start_job(8'h20, 8'h04, 8'd6, 8'd3, 4, 1'b0, -1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_tr_en) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rst_reach_run", 32'(ok), 1);
        i_rst = 1'b1;
        tick();
        check_outputs_zero("mid_reset");
        i_rst = 1'b0;
        tick();
        run_job(8'h10, 8'h08, 8'd4, 8'd3, 5, 1'b0, -1, 1'b0);

        // randomized jobs
        for (int j = 0; j < 24; j++) begin
            num = $urandom_range(1, 6);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, num - 1)) : -1;
            run_job(AW'($urandom_range(0, 255)), AW'($urandom_range(0, 255)),
                    AW'($urandom_range(1, 255)), TW'(num), int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)), ab, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
